clk_div_multi_prog: RTL and testbench
=====================================

Name: clk_div_multi_prog

Overview:
- Multi-channel programmable clock divider: successor to the fixed 50 MHz -> 100 Hz divider.
- Generates NUM_CH independent divided clock-enable waveforms from one system clock.
- Each channel has a runtime divisor with per-channel enable, a one-cycle tick at each period start, and glitch-free divisor updates applied only at period boundaries.
- Feeds timers, debouncers and display-scan logic that need several slow rates from clk_50mhz.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 20, counter/divisor width in bits; max divisor 2^CNT_W-1.
- DEFAULT_DIV, 500000, divisor loaded into every channel at reset (50 MHz -> 100 Hz); must satisfy 2 <= DEFAULT_DIV < 2^CNT_W.
- CH_IDX_W, 2, width of cfg_ch; must satisfy 2^CH_IDX_W >= NUM_CH.

Ports:
- clk_50mhz  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel run enable.
- cfg_valid  input  1  divisor write request.
- cfg_ch  input  CH_IDX_W  target channel of the write.
- cfg_div  input  CNT_W  new divisor D.
- cfg_ready  output  1  write slot available for cfg_ch (combinational).
- cfg_err  output  1  one-cycle pulse: last accepted write was illegal.
- clk_out  output  NUM_CH  divided waveforms, registered.
- tick  output  NUM_CH  one-cycle pulse coincident with each clk_out rising edge, registered.
- busy  output  NUM_CH  channel has a pending divisor not yet applied.

Behaviour:
- **Per-channel state:** active divisor D, counter cnt (0..D-1), pending divisor P with flag pv (= busy).
- **Reset (async):**
  - D = DEFAULT_DIV, cnt = DEFAULT_DIV-1, pv = 0.
  - clk_out = 0, tick = 0, cfg_err = 0.
- **Waveform:** H = D>>1 (floor).
  - clk_out is high for H cycles and low for D-H cycles; period is exactly D cycles.
  - Odd D gives the shorter high phase.
- **Enabled cycle, ch_en[i]=1:**
  - If cnt == D-1 (wrap): cnt <= 0, clk_out <= 1, tick <= 1; if pv, D <= P and pv <= 0. The new D governs the period that starts at this wrap.
  - Otherwise: cnt <= cnt+1, clk_out <= (cnt+1 < H_current), tick <= 0.
- **Disabled cycle, ch_en[i]=0:**
  - cnt <= D-1 (after any pending load), clk_out <= 0, tick <= 0.
  - If pv: D <= P and pv <= 0 immediately.
  - On re-enable, the first enabled cycle performs the wrap, so clk_out rises one cycle after ch_en goes high.
- **Config handshake:**
  - cfg_ready = !pv[cfg_ch] when cfg_ch < NUM_CH; otherwise 1.
  - A write is accepted on a cycle where cfg_valid && cfg_ready.
  - Legal write (2 <= cfg_div, cfg_ch < NUM_CH): P <= cfg_div, pv <= 1 at the next edge.
  - Illegal write (cfg_div < 2 or cfg_ch >= NUM_CH): dropped, no state change, cfg_err = 1 for exactly the next cycle.
  - cfg_valid while !cfg_ready: no effect; the requester holds its request.
- **Simultaneous events:**
  - Write accepted in the same cycle the target channel wraps: the wrap uses the pre-cycle pv/P. The new value is pending and applies at the following wrap.
  - Writes to different channels in consecutive cycles are independent.
- **Counter width:** cnt compares against D-1 in CNT_W bits; no overflow possible because D < 2^CNT_W.
- **Reset mid-period:** outputs drop to 0 asynchronously, and any pending write is lost.
- **Latency:** tick and clk_out are registered; tick[i] and clk_out[i] rise on the same edge.

Test Plan:
1. **Reset default:** NUM_CH=2, CNT_W=20, DEFAULT_DIV=500000, ch_en=2'b11 after reset release -> clk_out[0] period 500000 cycles, high 250000; tick every 500000 cycles starting 1 cycle after release.
2. **Odd divisor and glitch-free update:** with CNT_W=8, DEFAULT_DIV=4, write ch0 D=5 mid-period.
   - busy[0]=1 and cfg_ready=0 for ch0; the current period completes as 2 high / 2 low.
   - Subsequent periods are 2 high / 3 low; busy clears at the wrap.
3. **Illegal writes:** write ch1 D=1, then write to ch index 3 with NUM_CH=2 -> each gives a one-cycle cfg_err; divisors unchanged; busy stays 0.
4. **Write on wrap cycle:** D=4; a write of D=6 accepted on the cnt==3 cycle -> next period still 4; the one after is 6.
5. **Disable/enable:** D=4, drop ch_en[0] mid-high-phase -> clk_out[0]=0 next cycle.
   - A write of D=3 while disabled applies immediately (busy clears next cycle).
   - On re-enable, tick on the first edge, then a 1 high / 2 low pattern.
6. **Async reset mid-operation:** assert reset between clock edges with a pending write -> clk_out, tick, busy go 0 without a clock edge; after release, all channels run at DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_multi_prog.sv
// rtl/clk_div_multi_prog.sv - multi-channel programmable clock divider with glitch-free divisor updates
module clk_div_multi_prog #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 20,
    parameter int DEFAULT_DIV = 500000,
    parameter int CH_IDX_W    = 2
) (
    input  logic                clk_50mhz,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                cfg_valid,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   busy
);

    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] pv_all;
    logic              sel_pv;
    logic              ch_ok;
    logic              wr_accept;
    logic              wr_legal;

    always_comb begin
        ch_sel = '0;
        sel_pv = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_IDX_W'(i)) begin
                ch_sel[i] = 1'b1;
                sel_pv    = pv_all[i];
            end
        end
    end

    // Out-of-range channels always look ready so the illegal write is accepted and flagged.
    assign ch_ok     = ({1'b0, cfg_ch} < (CH_IDX_W + 1)'(NUM_CH));
    assign cfg_ready = ch_ok ? !sel_pv : 1'b1;
    assign wr_accept = cfg_valid && cfg_ready;
    assign wr_legal  = wr_accept && ch_ok && (cfg_div >= CNT_W'(2));

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= wr_accept && !wr_legal;
        end
    end

    assign busy = pv_all;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] pend_q;
        logic             pv_q;
        logic             clk_q;
        logic             tick_q;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] div_eff;
        logic             wrap;
        logic             wr_hit;

        assign cnt_inc = cnt_q + CNT_W'(1);
        assign half    = div_q >> 1;
        assign wrap    = (cnt_q == div_q - CNT_W'(1));
        assign div_eff = pv_q ? pend_q : div_q;
        assign wr_hit  = wr_legal && ch_sel[g];

        always_ff @(posedge clk_50mhz or posedge reset) begin
            if (reset) begin
                div_q  <= CNT_W'(DEFAULT_DIV);
                cnt_q  <= CNT_W'(DEFAULT_DIV - 1);
                pend_q <= '0;
                pv_q   <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (ch_en[g]) begin
                    if (wrap) begin
                        // The pending divisor takes over exactly at the period boundary.
                        cnt_q  <= '0;
                        clk_q  <= 1'b1;
                        tick_q <= 1'b1;
                        div_q  <= div_eff;
                    end else begin
                        cnt_q  <= cnt_inc;
                        clk_q  <= (cnt_inc < half);
                        tick_q <= 1'b0;
                    end
                end else begin
                    // Parked one step before wrap so re-enable starts a fresh period.
                    div_q  <= div_eff;
                    cnt_q  <= div_eff - CNT_W'(1);
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end

                if (wr_hit) begin
                    pend_q <= cfg_div;
                    pv_q   <= 1'b1;
                end else if (!ch_en[g] || wrap) begin
                    pv_q   <= 1'b0;
                end
            end
        end

        assign pv_all[g]  = pv_q;
        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_multi_prog.sv
// tb/tb_clk_div_multi_prog.sv - randomized and directed bench for clk_div_multi_prog
module tb_clk_div_multi_prog;

    localparam int NCH  = 2;
    localparam int CW   = 8;
    localparam int DDIV = 4;
    localparam int CIW  = 2;

    logic           clk_50mhz = 1'b0;
    logic           reset     = 1'b1;
    logic [NCH-1:0] ch_en     = '0;
    logic           cfg_valid = 1'b0;
    logic [CIW-1:0] cfg_ch    = '0;
    logic [CW-1:0]  cfg_div   = '0;
    logic           cfg_ready;
    logic           cfg_err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;

    int nvec = 0;
    int nerr = 0;

    // Reference: each channel is a period of D cycles, high while the position is below D/2.
    int             m_div [NCH];
    int             m_pend[NCH];
    int             m_pos [NCH];
    bit             m_pv  [NCH];
    logic [NCH-1:0] e_clk, e_tick, e_busy;
    logic           e_err;

    clk_div_multi_prog #(
        .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .CH_IDX_W(CIW)
    ) dut (
        .clk_50mhz(clk_50mhz), .reset(reset), .ch_en(ch_en),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick), .busy(busy)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    function automatic bit model_ready(int c);
        return (c >= NCH) ? 1'b1 : !m_pv[c];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DDIV;
            m_pos[i] = DDIV - 1;
            m_pv[i]  = 1'b0;
            m_pend[i] = 0;
        end
        e_clk = '0; e_tick = '0; e_busy = '0; e_err = 1'b0;
    endtask

    task automatic cycle();
        int c;
        bit acc, legal;
        c     = int'(cfg_ch);
        acc   = cfg_valid && model_ready(c);
        legal = acc && (c < NCH) && (int'(cfg_div) >= 2);
        for (int i = 0; i < NCH; i++) begin
            if (ch_en[i]) begin
                if (m_pos[i] >= m_div[i] - 1) begin
                    if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 1'b0; end
                    m_pos[i] = 0;
                    e_clk[i] = 1'b1; e_tick[i] = 1'b1;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                    e_clk[i] = (m_pos[i] < m_div[i] / 2); e_tick[i] = 1'b0;
                end
            end else begin
                if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 1'b0; end
                m_pos[i] = m_div[i] - 1;
                e_clk[i] = 1'b0; e_tick[i] = 1'b0;
            end
            if (legal && c == i) begin m_pend[i] = int'(cfg_div); m_pv[i] = 1'b1; end
        end
        for (int i = 0; i < NCH; i++) e_busy[i] = m_pv[i];
        e_err = acc && !legal;
        @(posedge clk_50mhz); #1;
    endtask

    task automatic test_reset();
        #1;
        nvec++;
        if ({clk_out, tick, busy, cfg_err, cfg_ready} !== 8'b0000_0001) begin
            nerr++; $display("FAIL reset_state got %b want %b", {clk_out, tick, busy, cfg_err, cfg_ready}, 8'b0000_0001);
        end
        model_reset();
        @(posedge clk_50mhz); #1;
        reset = 1'b0;
        ch_en = 2'b11;
        cycle();
        nvec++;
        if ({tick, clk_out} !== 4'b1111) begin
            nerr++; $display("FAIL reset_first_tick got %b want %b", {tick, clk_out}, 4'b1111);
        end
        for (int n = 0; n < 12; n++) begin
            cycle();
            nvec++;
            if ({clk_out, tick, busy, cfg_err} !== {e_clk, e_tick, e_busy, e_err}) begin
                nerr++; $display("FAIL reset_run cyc %0d got %b want %b", n, {clk_out, tick, busy, cfg_err}, {e_clk, e_tick, e_busy, e_err});
            end
        end
    endtask

    task automatic wait_pos(int ch, int pos, string name);
        int budget = 40;
        while (m_pos[ch] != pos && budget > 0) begin cycle(); budget--; end
        nvec++;
        if (budget == 0) begin nerr++; $display("FAIL %s_wait got timeout want pos %0d", name, pos); end
    endtask

    task automatic write_div(int ch, int d);
        cfg_valid = 1'b1; cfg_ch = CIW'(ch); cfg_div = CW'(d);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic test_odd_update();
        logic [12:0] pat;
        pat = 13'b0011000110001;
        wait_pos(0, 0, "odd");
        write_div(0, 5);
        nvec++;
        if (busy[0] !== 1'b1 || cfg_ready !== 1'b0) begin
            nerr++; $display("FAIL odd_pending got busy=%b ready=%b want busy=1 ready=0", busy[0], cfg_ready);
        end
        for (int n = 0; n < 13; n++) begin
            cycle();
            nvec++;
            if (clk_out[0] !== pat[12-n] || {clk_out, tick, busy, cfg_err} !== {e_clk, e_tick, e_busy, e_err}) begin
                nerr++; $display("FAIL odd_wave cyc %0d got %b want %b (clk0 %b)", n, {clk_out, tick, busy, cfg_err}, {e_clk, e_tick, e_busy, e_err}, pat[12-n]);
            end
        end
        nvec++;
        if (busy[0] !== 1'b0) begin nerr++; $display("FAIL odd_busy_clear got %b want 0", busy[0]); end
    endtask

    task automatic test_illegal();
        write_div(1, 1);
        nvec++;
        if (cfg_err !== 1'b1 || busy !== 2'b00) begin
            nerr++; $display("FAIL illegal_div got err=%b busy=%b want err=1 busy=00", cfg_err, busy);
        end
        write_div(3, 7);
        nvec++;
        if (cfg_err !== 1'b1 || busy !== 2'b00) begin
            nerr++; $display("FAIL illegal_ch got err=%b busy=%b want err=1 busy=00", cfg_err, busy);
        end
        cycle();
        nvec++;
        if (cfg_err !== 1'b0) begin nerr++; $display("FAIL illegal_pulse got %b want 0", cfg_err); end
        for (int n = 0; n < 10; n++) begin
            cycle();
            nvec++;
            if ({clk_out, tick, busy, cfg_err} !== {e_clk, e_tick, e_busy, e_err}) begin
                nerr++; $display("FAIL illegal_run cyc %0d got %b want %b", n, {clk_out, tick, busy, cfg_err}, {e_clk, e_tick, e_busy, e_err});
            end
        end
    endtask

    task automatic test_wrap_write();
        int gap;
        write_div(0, 4);
        wait_pos(0, 0, "wrap_setup");
        wait_pos(0, 3, "wrap");
        write_div(0, 6);
        nvec++;
        if (tick[0] !== 1'b1 || busy[0] !== 1'b1) begin
            nerr++; $display("FAIL wrap_edge got tick=%b busy=%b want 1 1", tick[0], busy[0]);
        end
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            do begin cycle(); gap++; end while (tick[0] !== 1'b1 && gap < 20);
            nvec++;
            if (gap != (k == 0 ? 4 : 6)) begin
                nerr++; $display("FAIL wrap_period%0d got %0d want %0d", k, gap, (k == 0 ? 4 : 6));
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0] pat;
        pat = 4'b1001;
        write_div(0, 4);
        wait_pos(0, 0, "dis_setup");
        wait_pos(0, 0, "dis");
        ch_en = 2'b10;
        cycle();
        nvec++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            nerr++; $display("FAIL dis_drop got clk=%b tick=%b want 0 0", clk_out[0], tick[0]);
        end
        write_div(0, 3);
        nvec++;
        if (busy[0] !== 1'b1) begin nerr++; $display("FAIL dis_pend got %b want 1", busy[0]); end
        cycle();
        nvec++;
        if (busy[0] !== 1'b0) begin nerr++; $display("FAIL dis_apply got %b want 0", busy[0]); end
        ch_en = 2'b11;
        for (int n = 0; n < 4; n++) begin
            cycle();
            nvec++;
            if (clk_out[0] !== pat[3-n] || tick[0] !== pat[3-n] || {clk_out, tick} !== {e_clk, e_tick}) begin
                nerr++; $display("FAIL dis_reen cyc %0d got clk=%b tick=%b want %b", n, clk_out[0], tick[0], pat[3-n]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(15) == 0) ch_en[$urandom_range(NCH-1)] ^= 1'b1;
            cfg_valid = ($urandom_range(2) == 0);
            cfg_ch    = CIW'($urandom_range(3));
            cfg_div   = CW'($urandom_range(9));
            #1;
            nvec++;
            if (cfg_ready !== model_ready(int'(cfg_ch))) begin
                nerr++; $display("FAIL rand_ready cyc %0d got %b want %b", n, cfg_ready, model_ready(int'(cfg_ch)));
            end
            cycle();
            nvec++;
            if ({clk_out, tick, busy, cfg_err} !== {e_clk, e_tick, e_busy, e_err}) begin
                nerr++; $display("FAIL rand_run cyc %0d got %b want %b", n, {clk_out, tick, busy, cfg_err}, {e_clk, e_tick, e_busy, e_err});
            end
        end
        cfg_valid = 1'b0;
        ch_en = 2'b11;
    endtask

    task automatic test_async_reset();
        int budget = 40;
        cfg_ch = 2'd1;
        while (cfg_ready !== 1'b1 && budget > 0) begin cycle(); budget--; end
        write_div(1, 9);
        nvec++;
        if (busy[1] !== 1'b1) begin nerr++; $display("FAIL areset_pend got %b want 1", busy[1]); end
        #2;
        reset = 1'b1;
        #1;
        nvec++;
        if ({clk_out, tick, busy, cfg_err} !== 7'b0) begin
            nerr++; $display("FAIL areset_async got %b want %b", {clk_out, tick, busy, cfg_err}, 7'b0);
        end
        model_reset();
        @(posedge clk_50mhz); #1;
        reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            nvec++;
            if ({clk_out, tick, busy, cfg_err} !== {e_clk, e_tick, e_busy, e_err}) begin
                nerr++; $display("FAIL areset_run cyc %0d got %b want %b", n, {clk_out, tick, busy, cfg_err}, {e_clk, e_tick, e_busy, e_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_odd_update();
        test_illegal();
        test_wrap_write();
        test_disable();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
